// File: rtl/pll_seq_pkg.sv
// pll_seq_pkg: shared state encoding and counter sizing for the PLL lock sequencer.
package pll_seq_pkg;

    typedef enum logic [2:0] {RST_PLL, WAIT_LOCK, STABLE, RUN, FAIL} state_t;

    function automatic int cnt_width(int a, int b, int c);
        int m;
        m = a > b ? a : b;
        m = m > c ? m : c;
        return $clog2(m + 1);
    endfunction

endpackage

// File: rtl/sync_ff.sv
// sync_ff: multi-flop synchroniser for a single asynchronous bit, reset to 0.
module sync_ff #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic [STAGES-1:0] ff;

    always_ff @(posedge clk or posedge rst)
        if (rst) ff <= '0;
        else     ff <= {ff[STAGES-2:0], d};

    assign q = ff[STAGES-1];

endmodule

// File: rtl/pll_lock_sequencer.sv
// pll_lock_sequencer: PLL reset/lock bring-up with timeout, retries and lock-loss handling.
// Define PLL_RELOCK_RESET_EN to re-pulse PLL RST with a fresh retry budget on lock loss in RUN.
module pll_lock_sequencer
    import pll_seq_pkg::*;
#(
    parameter int RST_CYCLES    = 16,
    parameter int LOCK_TIMEOUT  = 25000,
    parameter int STABLE_CYCLES = 256,
    parameter int MAX_RETRIES   = 3,
    parameter int SYNC_STAGES   = 2
) (
    input  logic                             clkin,
    input  logic                             reset,
    input  logic                             pll_lock,
    output logic                             pll_rst,
    output logic                             sys_rst,
    output logic                             ready,
    output logic                             fail,
    output logic [$clog2(MAX_RETRIES+2)-1:0] attempts
);

    localparam int CW = cnt_width(RST_CYCLES, LOCK_TIMEOUT, STABLE_CYCLES);
    localparam int AW = $clog2(MAX_RETRIES + 2);
    localparam logic [AW-1:0] LAST = AW'(MAX_RETRIES + 1);

    state_t        state;
    logic [CW-1:0] cnt;
    logic          lock_s;

    sync_ff #(.STAGES(SYNC_STAGES)) u_sync (
        .clk(clkin),
        .rst(reset),
        .d  (pll_lock),
        .q  (lock_s)
    );

    always_ff @(posedge clkin or posedge reset) begin
        if (reset) begin
            state    <= RST_PLL;
            cnt      <= '0;
            pll_rst  <= 1'b1;
            sys_rst  <= 1'b1;
            ready    <= 1'b0;
            fail     <= 1'b0;
            attempts <= '0;
        end else begin
            cnt <= cnt + 1'b1;
            case (state)
                RST_PLL:
                    if (cnt == CW'(RST_CYCLES - 1)) begin
                        state   <= WAIT_LOCK;
                        cnt     <= '0;
                        pll_rst <= 1'b0;
                        if (attempts != LAST) attempts <= attempts + 1'b1;
                    end
                // lock is tested before the timeout so it wins a same-cycle tie
                WAIT_LOCK:
                    if (lock_s) begin
                        state <= STABLE;
                        cnt   <= '0;
                    end else if (cnt == CW'(LOCK_TIMEOUT - 1)) begin
                        cnt     <= '0;
                        pll_rst <= 1'b1;
                        if (attempts >= LAST) begin
                            state <= FAIL;
                            fail  <= 1'b1;
                        end else begin
                            state <= RST_PLL;
                        end
                    end
                STABLE:
                    if (!lock_s) begin
                        state <= WAIT_LOCK;
                        cnt   <= '0;
                    end else if (cnt == CW'(STABLE_CYCLES - 1)) begin
                        state   <= RUN;
                        cnt     <= '0;
                        sys_rst <= 1'b0;
                        ready   <= 1'b1;
                    end
                RUN:
                    if (!lock_s) begin
                        cnt     <= '0;
                        sys_rst <= 1'b1;
                        ready   <= 1'b0;
`ifdef PLL_RELOCK_RESET_EN
                        state    <= RST_PLL;
                        pll_rst  <= 1'b1;
                        attempts <= '0;
`else
                        state <= WAIT_LOCK;
`endif
                    end
                FAIL:    state <= FAIL;
                default: state <= RST_PLL;
            endcase
        end
    end

endmodule

// File: tb/tb_pll_lock_sequencer.sv
// tb_pll_lock_sequencer: scoreboard bench; expected output-change events are queued as stimulus is driven.
module tb_pll_lock_sequencer;

    localparam int RC = 16;
    localparam int LT = 300;
    localparam int SC = 256;
    localparam int MR = 3;
    localparam int AW = $clog2(MR + 2);
    localparam int PER = RC + LT;
    localparam logic [6:0] RST_V = 7'b1100_000;

    typedef struct {
        logic [6:0] v;
        int         c;
    } evt_t;

    logic clkin = 1'b0;
    logic reset = 1'b1;
    logic pll_lock = 1'b0;
    logic pll_rst, sys_rst, ready, fail;
    logic [AW-1:0] attempts;
    logic [6:0] obs;
    logic [6:0] prev = RST_V;
    int cyc = 0;
    int checks = 0;
    int failures = 0;
    int d;
    evt_t q[$];
    evt_t e;

    pll_lock_sequencer #(
        .RST_CYCLES   (RC),
        .LOCK_TIMEOUT (LT),
        .STABLE_CYCLES(SC),
        .MAX_RETRIES  (MR),
        .SYNC_STAGES  (2)
    ) dut (
        .clkin   (clkin),
        .reset   (reset),
        .pll_lock(pll_lock),
        .pll_rst (pll_rst),
        .sys_rst (sys_rst),
        .ready   (ready),
        .fail    (fail),
        .attempts(attempts)
    );

    always #5 clkin = ~clkin;

    assign obs = {pll_rst, sys_rst, ready, fail, attempts};

    always @(posedge clkin or posedge reset)
        if (reset) cyc <= 0;
        else       cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0d exp=%0d (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // any change of outputs/attempts must match the next queued event
    always @(negedge clkin) begin
        if (reset) prev = RST_V;
        else if (obs !== prev) begin
            if (q.size() == 0) check("unexpected_change", obs, prev);
            else begin
                e = q.pop_front();
                check("evt_out", obs, e.v);
                check("evt_cyc", cyc, e.c);
            end
            prev = obs;
        end
    end

    task automatic push(input logic p, input logic s, input logic r, input logic f, input int a, input int c);
        evt_t x;
        x.v = {p, s, r, f, AW'(a)};
        x.c = c;
        q.push_back(x);
    endtask

    task automatic push_seq(input int n);
        for (int k = 0; k < n; k++) begin
            push(0, 1, 0, 0, k + 1, RC + PER * k);
            if (k < n - 1) push(1, 1, 0, 0, k + 1, PER * (k + 1));
        end
    endtask

    task automatic chk_rst();
        check("rst_pll_rst", pll_rst, 1);
        check("rst_sys_rst", sys_rst, 1);
        check("rst_ready", ready, 0);
        check("rst_fail", fail, 0);
        check("rst_attempts", attempts, 0);
    endtask

    task automatic hit_reset();
        @(posedge clkin);
        #3;
        reset = 1'b1;
        pll_lock = 1'b0;
        #1;
        chk_rst();
        q.delete();
        repeat (2) @(negedge clkin);
        reset = 1'b0;
    endtask

    task automatic wait_cyc(input int n);
        for (int i = 0; i < 5000 && cyc < n; i++) @(negedge clkin);
        if (cyc != n) check("wait_cyc", cyc, n);
    endtask

    task automatic drain();
        for (int i = 0; i < 3000 && q.size() != 0; i++) @(posedge clkin);
        check("drain", q.size(), 0);
        q.delete();
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        // nominal bring-up: lock 100 cycles after pll_rst falls
        hit_reset();
        push_seq(1);
        wait_cyc(RC + 100);
        pll_lock = 1'b1;
        push(0, 0, 1, 0, 1, cyc + 3 + SC);
        drain();
        check("nom_ready", ready, 1);
        check("nom_attempts", attempts, 1);

        // lock loss in RUN, then relock 50 cycles later
        d = cyc + 10;
        wait_cyc(d);
        pll_lock = 1'b0;
`ifdef PLL_RELOCK_RESET_EN
        push(1, 1, 0, 0, 0, d + 3);
        push(0, 1, 0, 0, 1, d + 3 + RC);
`else
        push(0, 1, 0, 0, 1, d + 3);
`endif
        wait_cyc(d + 50);
        pll_lock = 1'b1;
        push(0, 0, 1, 0, 1, cyc + 3 + SC);
        drain();

        // reset mid-RUN, then a 3-cycle glitch 100 cycles into STABLE
        hit_reset();
        push_seq(1);
        wait_cyc(RC + 100);
        pll_lock = 1'b1;
        wait_cyc(RC + 203);
        pll_lock = 1'b0;
        wait_cyc(RC + 206);
        pll_lock = 1'b1;
        push(0, 0, 1, 0, 1, cyc + 3 + SC);
        drain();
        check("glitch_attempts", attempts, 1);

        // reset mid-WAIT_LOCK
        hit_reset();
        push_seq(1);
        wait_cyc(RC + 80);
        check("wl_q_consumed", q.size(), 0);
        hit_reset();

        // never locks: four pulses then sticky FAIL
        push_seq(MR + 1);
        push(1, 1, 0, 1, MR + 1, RC + PER * MR + LT);
        drain();
        repeat (20) @(negedge clkin);
        check("fail_sticky", fail, 1);
        check("fail_pll_rst", pll_rst, 1);
        check("fail_attempts", attempts, MR + 1);

        // lock_s rises exactly on the last-attempt timeout cycle: lock wins
        hit_reset();
        push_seq(MR + 1);
        wait_cyc(RC + PER * MR + LT - 3);
        pll_lock = 1'b1;
        push(0, 0, 1, 0, MR + 1, cyc + 3 + SC);
        drain();
        check("tie_fail", fail, 0);
        check("tie_ready", ready, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
